// File: rtl/serial_frame_tx_if.sv
// Word-input / serial-output bundle for serial_frame_tx.
// Latency: none (wires only); timing is set by the transmitter.
// Backpressure: ready low while a frame is on the line; valid is ignored then.
// Ports: data_in/valid in, ready/tx/busy/done out (as seen by the transmitter).
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic              tx;
  logic              busy;
  logic              done;

  // Word source / line observer.
  modport master (
    output data_in, valid,
    input  ready, tx, busy, done
  );

  // Transmitter side.
  modport slave (
    input  data_in, valid,
    output ready, tx, busy, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start(0), data LSB-first, optional even parity, stop(1).
// Latency: start bit on tx the cycle after acceptance; frame is (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles.
// Backpressure: ready drops on acceptance and returns with done at the end of the stop bit.
// Ports: clk, rst (async, active-high), bus.slave {data_in, valid, ready, tx, busy, done}.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  serial_frame_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic              par;
  logic              bit_end;

  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  assign bit_end    = (baud_cnt == CNT_LAST);
  assign shreg_next = shreg >> 1;

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  // tx is driven one bit ahead: every transition loads the value of the bit
  // that starts on the following cycle, so the line itself is a flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Baud counter only runs while a frame is on the line.
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.valid && ready_q) begin
            shreg    <= bus.data_in;
            par      <= ^bus.data_in;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tx_q  <= shreg[0];
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx_q  <= par;
                state <= PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg_next;
              tx_q    <= shreg_next[0];
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            tx_q  <= 1'b1;
            state <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances (defaults, no parity, 1 clk/bit with 4-bit data).
// Latency: expected frames are queued at issue; per-instance monitors check tx every cycle.
// Backpressure: frames are only issued while the target instance is idle or holding valid.
module tb_serial_frame_tx;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  serial_frame_tx_if #(.DATA_W(8)) if_a ();
  serial_frame_tx_if #(.DATA_W(8)) if_b ();
  serial_frame_tx_if #(.DATA_W(4)) if_c ();

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_c (
    .clk(clk), .rst(rst), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame: bit sequence as written on the line, first bit at pat[n-1].
  typedef struct {
    logic [15:0] pat;
    int          n;
    bit          abort;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {tx, ready, busy, done}
  function automatic logic [3:0] sig(input int id);
    case (id)
      0:       return {if_a.tx, if_a.ready, if_a.busy, if_a.done};
      1:       return {if_b.tx, if_b.ready, if_b.busy, if_b.done};
      default: return {if_c.tx, if_c.ready, if_c.busy, if_c.done};
    endcase
  endfunction

  task automatic push(input int id, input logic [15:0] pat, input int n, input bit abort);
    exp_t e;
    e.pat = pat;
    e.n = n;
    e.abort = abort;
    case (id)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic pop(input int id, output exp_t e, output bit ok);
    ok = 1'b0;
    e.pat = '0;
    e.n = 0;
    e.abort = 1'b0;
    case (id)
      0:       if (q_a.size() > 0) begin e = q_a.pop_front(); ok = 1'b1; end
      1:       if (q_b.size() > 0) begin e = q_b.pop_front(); ok = 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic monitor(input int id, input int cpb);
    exp_t       e;
    bit         ok;
    bit         aborted;
    logic [3:0] s;
    logic       b;
    forever begin
      @(negedge clk);
      s = sig(id);
      if (!s[1]) begin
        check($sformatf("idle_d%0d", id), 32'(s), 32'h0000_000c);
        continue;
      end
      pop(id, e, ok);
      if (!ok) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_frame_d%0d: actual busy=1 required no frame (t=%0t)", id, $time);
        while (s[1]) begin
          @(negedge clk);
          s = sig(id);
        end
        continue;
      end
      aborted = 1'b0;
      for (int k = 0; k < e.n * cpb; k++) begin
        if (k > 0) begin
          @(negedge clk);
          s = sig(id);
        end
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        b = e.pat[e.n - 1 - k / cpb];
        check($sformatf("frame_d%0d_cyc%0d", id, k), 32'(s), 32'({b, 3'b010}));
      end
      if (aborted || e.abort)
        check($sformatf("abort_d%0d", id), 32'(aborted), 32'(e.abort));
      if (!aborted) begin
        @(negedge clk);
        s = sig(id);
        check($sformatf("frame_end_d%0d", id), 32'(s), 32'h0000_000d);
      end
    end
  endtask

  initial monitor(0, 4);
  initial monitor(1, 4);
  initial monitor(2, 1);

  // Single accepted word on instance a/b (8-bit) or c (4-bit).
  task automatic send(input int id, input logic [7:0] w);
    @(negedge clk);
    case (id)
      0:       begin if_a.data_in = w; if_a.valid = 1'b1; end
      1:       begin if_b.data_in = w; if_b.valid = 1'b1; end
      default: begin if_c.data_in = w[3:0]; if_c.valid = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    if_a.valid = 1'b0;
    if_b.valid = 1'b0;
    if_c.valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    if_a.valid = 1'b0; if_a.data_in = '0;
    if_b.valid = 1'b0; if_b.data_in = '0;
    if_c.valid = 1'b0; if_c.data_in = '0;

    // Reset state on every instance.
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", 32'(sig(0)), 32'h0000_000c);
    check("reset_b", 32'(sig(1)), 32'h0000_000c);
    check("reset_c", 32'(sig(2)), 32'h0000_000c);
    @(negedge clk);
    rst = 1'b0;

    // Idle: monitors check tx=1, ready=1, busy=0, done=0 every cycle.
    repeat (50) @(posedge clk);

    // 0xA5: 0 | 1 0 1 0 0 1 0 1 | p=0 | 1
    push(0, 16'(11'b0_10100101_0_1), 11, 1'b0);
    send(0, 8'hA5);
    repeat (55) @(posedge clk);

    // 0x07: 0 | 1 1 1 0 0 0 0 0 | p=1 | 1
    push(0, 16'(11'b0_11100000_1_1), 11, 1'b0);
    send(0, 8'h07);
    repeat (55) @(posedge clk);

    // 0x07 without parity: 40-cycle frame.
    push(1, 16'(10'b0_11100000_1), 10, 1'b0);
    send(1, 8'h07);
    repeat (50) @(posedge clk);

    // Back-to-back, data_in changed mid-frame.
    // 0x3C: 0 | 0 0 1 1 1 1 0 0 | p=0 | 1 ; 0xFF: 0 | 1x8 | p=0 | 1
    push(0, 16'(11'b0_00111100_0_1), 11, 1'b0);
    push(0, 16'(11'b0_11111111_0_1), 11, 1'b0);
    @(negedge clk);
    if_a.data_in = 8'h3C;
    if_a.valid = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    if_a.data_in = 8'hFF;
    repeat (35) @(posedge clk);
    #1;
    if_a.valid = 1'b0;
    repeat (55) @(posedge clk);

    // Reset during data bit 3 of 0x00.
    push(0, 16'(11'b0_00000000_0_1), 11, 1'b1);
    send(0, 8'h00);
    repeat (16) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_abort_a", 32'(sig(0)), 32'h0000_000c);
    repeat (3) @(negedge clk);
    // valid raised in the same cycle reset releases.
    push(0, 16'(11'b0_10000001_0_1), 11, 1'b0);
    rst = 1'b0;
    if_a.data_in = 8'h81;
    if_a.valid = 1'b1;
    @(posedge clk);
    #1;
    if_a.valid = 1'b0;
    repeat (55) @(posedge clk);

    // 4-bit, 1 clk/bit, 0xA: 0 | 0 1 0 1 | p=0 | 1
    push(2, 16'(7'b0_0101_0_1), 7, 1'b0);
    send(2, 8'h0A);
    repeat (15) @(posedge clk);

    check("queue_empty_a", 32'(q_a.size()), 32'd0);
    check("queue_empty_b", 32'(q_b.size()), 32'd0);
    check("queue_empty_c", 32'(q_c.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
